// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle CPU control unit: fetch/decode/execute/writeback sequencing with
// memory-ready handshake, timeout, condition evaluation and sticky fault halt.
module multicycle_ctrl_fsm #(
    parameter int DATA_W      = 16,
    parameter int IMM_W       = 8,
    parameter int NREG        = 16,
    parameter int REG_AW      = 4,
    parameter int OP_W        = 8,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        instr_class,
    input  logic [OP_W-1:0]   opcode_in,
    input  logic [REG_AW-1:0] rdst_in,
    input  logic [REG_AW-1:0] rsrc_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic              imm_signed,
    input  logic [3:0]        cond_in,
    input  logic [4:0]        flags,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic [1:0]        pc_sel,
    output logic              IR_enable,
    output logic              flag_enable,
    output logic              imm_mux,
    output logic              tristate_en,
    output logic              mem_req,
    output logic              we_enable,
    output logic              ls_control,
    output logic [NREG-1:0]   reg_we,
    output logic [REG_AW-1:0] rsrc_out,
    output logic [REG_AW-1:0] rdst_out,
    output logic [OP_W-1:0]   opcode_out,
    output logic [DATA_W-1:0] immediate_out,
    output logic              illegal_instr,
    output logic              bus_error,
    output logic [3:0]        state_output
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXR    = 4'd3,
        S_EXI    = 4'd4,
        S_STOR   = 4'd5,
        S_LDA    = 4'd6,
        S_LDW    = 4'd7,
        S_BR     = 4'd8,
        S_NOP    = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_illegal;
    logic              r_bus_err;
    logic              w_set_ill;
    logic              w_set_bus;
    logic              w_wait_state;
    logic              w_to_hit;
    logic              w_taken;
    logic [NREG-1:0]   w_reg_we_dec;
    logic [DATA_W-1:0] w_imm_ext;

    // Indices at or beyond NREG match no decoder line, giving an all-zero enable.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg_we
            assign w_reg_we_dec[gi] = (32'(rdst_in) == 32'(gi));
        end
        if (DATA_W > IMM_W) begin : g_ext
            assign w_imm_ext = {{(DATA_W-IMM_W){imm_signed & imm_in[IMM_W-1]}}, imm_in};
        end else begin : g_noext
            assign w_imm_ext = imm_in;
        end
    endgenerate

    // flags = {C, L, F, Z, N}
    always_comb begin
        w_taken = 1'b0;
        case (cond_in)
            4'h0: w_taken =  flags[1];
            4'h1: w_taken = ~flags[1];
            4'h2: w_taken =  flags[4];
            4'h3: w_taken = ~flags[4];
            4'h4: w_taken =  flags[3];
            4'h5: w_taken = ~flags[3];
            4'h6: w_taken =  flags[0];
            4'h7: w_taken = ~flags[0];
            4'h8: w_taken =  flags[2];
            4'h9: w_taken = ~flags[2];
            4'hA: w_taken = ~flags[3] & ~flags[1];
            4'hB: w_taken =  flags[3] |  flags[1];
            4'hC: w_taken = ~flags[0] & ~flags[1];
            4'hD: w_taken =  flags[0] |  flags[1];
            4'hE: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_STOR) || (r_state == S_LDA);
    // A mem_ready arriving on the limit cycle still completes the transfer.
    assign w_to_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                      (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        w_set_ill    = 1'b0;
        w_set_bus    = 1'b0;
        case (r_state)
            S_RST:   w_state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    w_state_next = S_DECODE;
                end else if (w_to_hit) begin
                    w_state_next = S_HALT;
                    w_set_bus    = 1'b1;
                end
            end
            S_DECODE: begin
                case (instr_class)
                    4'b0000: w_state_next = S_NOP;
                    4'b0001: w_state_next = S_EXR;
                    4'b0010: w_state_next = S_EXI;
                    4'b0100: w_state_next = S_LDA;
                    4'b0101: w_state_next = S_STOR;
                    4'b1000,
                    4'b1100: w_state_next = S_BR;
                    default: begin
                        w_state_next = S_HALT;
                        w_set_ill    = 1'b1;
                    end
                endcase
            end
            S_EXR, S_EXI, S_LDW, S_BR, S_NOP: w_state_next = S_FETCH;
            S_STOR: begin
                if (mem_ready) begin
                    w_state_next = S_FETCH;
                end else if (w_to_hit) begin
                    w_state_next = S_HALT;
                    w_set_bus    = 1'b1;
                end
            end
            S_LDA: begin
                if (mem_ready) begin
                    w_state_next = S_LDW;
                end else if (w_to_hit) begin
                    w_state_next = S_HALT;
                    w_set_bus    = 1'b1;
                end
            end
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RST;
            r_to_cnt  <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_set_ill) r_illegal <= 1'b1;
            if (w_set_bus) r_bus_err <= 1'b1;
            // Any state change clears the wait counter; it saturates when waiting forever.
            if (w_state_next != r_state) begin
                r_to_cnt <= '0;
            end else if (w_wait_state && !mem_ready && (r_to_cnt != '1)) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    always_comb begin
        pc_en         = 1'b0;
        pc_sel        = 2'b00;
        IR_enable     = 1'b0;
        flag_enable   = 1'b0;
        imm_mux       = 1'b0;
        tristate_en   = 1'b0;
        mem_req       = 1'b0;
        we_enable     = 1'b0;
        ls_control    = 1'b0;
        reg_we        = '0;
        rsrc_out      = '0;
        rdst_out      = '0;
        opcode_out    = '0;
        immediate_out = '0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                IR_enable = mem_ready;
            end
            S_EXR, S_EXI: begin
                opcode_out  = opcode_in;
                rsrc_out    = (r_state == S_EXI) ? rdst_in : rsrc_in;
                rdst_out    = rdst_in;
                flag_enable = 1'b1;
                reg_we      = w_reg_we_dec;
                pc_en       = 1'b1;
                if (r_state == S_EXI) begin
                    imm_mux       = 1'b1;
                    immediate_out = w_imm_ext;
                end
            end
            S_STOR: begin
                rsrc_out   = rsrc_in;
                rdst_out   = rdst_in;
                ls_control = 1'b1;
                mem_req    = 1'b1;
                we_enable  = 1'b1;
                pc_en      = mem_ready;
            end
            S_LDA: begin
                rdst_out   = rsrc_in;
                ls_control = 1'b1;
                mem_req    = 1'b1;
            end
            S_LDW: begin
                tristate_en = 1'b1;
                reg_we      = w_reg_we_dec;
                pc_en       = 1'b1;
            end
            S_BR: begin
                pc_en    = 1'b1;
                rdst_out = rdst_in;
                if (w_taken) pc_sel = (instr_class == 4'b1100) ? 2'b01 : 2'b10;
            end
            S_NOP:   pc_en = 1'b1;
            default: ;
        endcase
    end

    assign illegal_instr = r_illegal;
    assign bus_error     = r_bus_err;
    assign state_output  = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: expectations are queued as each step is
// driven and popped/compared once the DUT outputs have settled.
module tb_multicycle_ctrl_fsm;

    localparam int DATA_W = 16, IMM_W = 8, NREG = 16, REG_AW = 4, OP_W = 8;
    localparam int MEM_TIMEOUT = 15, TO_W = 4;

    localparam int S_ALL = 0, S_STATE = 1, S_PCEN = 2, S_PCSEL = 3, S_IREN = 4,
                   S_FLAG = 5, S_IMMMUX = 6, S_TRI = 7, S_MREQ = 8, S_WE = 9,
                   S_LS = 10, S_REGWE = 11, S_RSRC = 12, S_RDST = 13, S_OP = 14,
                   S_IMM = 15, S_ILL = 16, S_BUS = 17;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        instr_class;
    logic [OP_W-1:0]   opcode_in;
    logic [REG_AW-1:0] rdst_in, rsrc_in;
    logic [IMM_W-1:0]  imm_in;
    logic              imm_signed;
    logic [3:0]        cond_in;
    logic [4:0]        flags;
    logic              mem_ready;
    logic              pc_en, IR_enable, flag_enable, imm_mux, tristate_en;
    logic              mem_req, we_enable, ls_control, illegal_instr, bus_error;
    logic [1:0]        pc_sel;
    logic [NREG-1:0]   reg_we;
    logic [REG_AW-1:0] rsrc_out, rdst_out;
    logic [OP_W-1:0]   opcode_out;
    logic [DATA_W-1:0] immediate_out;
    logic [3:0]        state_output;

    typedef struct {
        string       tag;
        int          sig;
        logic [63:0] val;
    } exp_t;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    multicycle_ctrl_fsm #(
        .DATA_W(DATA_W), .IMM_W(IMM_W), .NREG(NREG), .REG_AW(REG_AW),
        .OP_W(OP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset), .instr_class(instr_class), .opcode_in(opcode_in),
        .rdst_in(rdst_in), .rsrc_in(rsrc_in), .imm_in(imm_in), .imm_signed(imm_signed),
        .cond_in(cond_in), .flags(flags), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_sel(pc_sel), .IR_enable(IR_enable), .flag_enable(flag_enable),
        .imm_mux(imm_mux), .tristate_en(tristate_en), .mem_req(mem_req),
        .we_enable(we_enable), .ls_control(ls_control), .reg_we(reg_we),
        .rsrc_out(rsrc_out), .rdst_out(rdst_out), .opcode_out(opcode_out),
        .immediate_out(immediate_out), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .state_output(state_output)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] get_obs(int sig);
        case (sig)
            S_ALL:    get_obs = {pc_en, pc_sel, IR_enable, flag_enable, imm_mux, tristate_en,
                                 mem_req, we_enable, ls_control, reg_we, rsrc_out, rdst_out,
                                 opcode_out, immediate_out, illegal_instr, bus_error, state_output};
            S_STATE:  get_obs = 64'(state_output);
            S_PCEN:   get_obs = 64'(pc_en);
            S_PCSEL:  get_obs = 64'(pc_sel);
            S_IREN:   get_obs = 64'(IR_enable);
            S_FLAG:   get_obs = 64'(flag_enable);
            S_IMMMUX: get_obs = 64'(imm_mux);
            S_TRI:    get_obs = 64'(tristate_en);
            S_MREQ:   get_obs = 64'(mem_req);
            S_WE:     get_obs = 64'(we_enable);
            S_LS:     get_obs = 64'(ls_control);
            S_REGWE:  get_obs = 64'(reg_we);
            S_RSRC:   get_obs = 64'(rsrc_out);
            S_RDST:   get_obs = 64'(rdst_out);
            S_OP:     get_obs = 64'(opcode_out);
            S_IMM:    get_obs = 64'(immediate_out);
            S_ILL:    get_obs = 64'(illegal_instr);
            S_BUS:    get_obs = 64'(bus_error);
            default:  get_obs = 'x;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(string tag, int sig, logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle mid-cycle, then drain the scoreboard.
    task automatic check();
        exp_t        e;
        logic [63:0] obs;
        #2;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = get_obs(e.sig);
            n_cmp++;
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
            $display("t=%0t %s observed=%0h expected=%0h", $time, e.tag, obs, e.val);
        end
    endtask

    // Called while in FETCH; returns one edge after DECODE, i.e. in the routed state.
    task automatic fetch_decode(logic [3:0] cls, string tag);
        instr_class = cls;
        mem_ready   = 1'b1;
        exp_push({tag, "_fetch_state"}, S_STATE, 64'd1);
        exp_push({tag, "_fetch_mem_req"}, S_MREQ, 64'd1);
        exp_push({tag, "_fetch_ir_en"}, S_IREN, 64'd1);
        check();
        cyc();
        mem_ready = 1'b0;
        exp_push({tag, "_decode_state"}, S_STATE, 64'd2);
        exp_push({tag, "_decode_pc_en"}, S_PCEN, 64'd0);
        check();
        cyc();
    endtask

    logic [3:0] br_cls  [4] = '{4'b1100, 4'b1100, 4'b1000, 4'b1000};
    logic [3:0] br_cond [4] = '{4'h0, 4'h0, 4'hE, 4'hF};
    logic [4:0] br_flags[4] = '{5'b00010, 5'b00000, 5'b00000, 5'b00000};
    logic [1:0] br_sel  [4] = '{2'b01, 2'b00, 2'b10, 2'b00};

    initial begin
        reset = 1'b0; instr_class = '0; opcode_in = '0; rdst_in = '0; rsrc_in = '0;
        imm_in = '0; imm_signed = 1'b0; cond_in = '0; flags = '0; mem_ready = 1'b0;
        repeat (2) cyc();
        exp_push("reset_all_zero", S_ALL, 64'd0);
        check();
        reset = 1'b1;
        cyc();

        // R-type
        opcode_in = 8'h2A; rdst_in = 4'd3; rsrc_in = 4'd5;
        fetch_decode(4'b0001, "rtype");
        exp_push("exr_state", S_STATE, 64'd3);
        exp_push("exr_reg_we", S_REGWE, 64'h0008);
        exp_push("exr_flag_en", S_FLAG, 64'd1);
        exp_push("exr_pc_en", S_PCEN, 64'd1);
        exp_push("exr_opcode", S_OP, 64'h2A);
        exp_push("exr_rsrc", S_RSRC, 64'd5);
        exp_push("exr_rdst", S_RDST, 64'd3);
        exp_push("exr_imm_mux", S_IMMMUX, 64'd0);
        check();
        cyc();

        // I-type, signed then unsigned extension
        for (int k = 0; k < 2; k++) begin
            rdst_in = 4'd7; imm_in = 8'hF0; imm_signed = (k == 0);
            fetch_decode(4'b0010, "itype");
            exp_push("exi_state", S_STATE, 64'd4);
            exp_push("exi_imm", S_IMM, (k == 0) ? 64'hFFF0 : 64'h00F0);
            exp_push("exi_imm_mux", S_IMMMUX, 64'd1);
            exp_push("exi_rsrc", S_RSRC, 64'd7);
            exp_push("exi_reg_we", S_REGWE, 64'h0080);
            exp_push("exi_flag_en", S_FLAG, 64'd1);
            check();
            cyc();
        end

        // Branches / jumps
        for (int k = 0; k < 4; k++) begin
            rdst_in = 4'd6; cond_in = br_cond[k]; flags = br_flags[k];
            fetch_decode(br_cls[k], "branch");
            exp_push("br_state", S_STATE, 64'd8);
            exp_push("br_pc_sel", S_PCSEL, 64'(br_sel[k]));
            exp_push("br_pc_en", S_PCEN, 64'd1);
            exp_push("br_rdst", S_RDST, 64'd6);
            check();
            cyc();
        end
        flags = '0;

        fetch_decode(4'b0000, "nop");
        exp_push("nop_state", S_STATE, 64'd9);
        exp_push("nop_pc_en", S_PCEN, 64'd1);
        check();
        cyc();

        // LOAD with five wait cycles
        rsrc_in = 4'd9; rdst_in = 4'd2;
        fetch_decode(4'b0100, "load");
        for (int i = 0; i < 6; i++) begin
            mem_ready = (i == 5);
            exp_push("lda_state", S_STATE, 64'd6);
            exp_push("lda_rdst", S_RDST, 64'd9);
            exp_push("lda_ls", S_LS, 64'd1);
            exp_push("lda_mem_req", S_MREQ, 64'd1);
            check();
            cyc();
        end
        mem_ready = 1'b0;
        exp_push("ldw_state", S_STATE, 64'd7);
        exp_push("ldw_tristate", S_TRI, 64'd1);
        exp_push("ldw_reg_we", S_REGWE, 64'h0004);
        exp_push("ldw_pc_en", S_PCEN, 64'd1);
        check();
        cyc();
        exp_push("post_ldw_state", S_STATE, 64'd1);
        exp_push("post_ldw_tristate", S_TRI, 64'd0);
        check();

        // Asynchronous reset in the middle of LDA
        fetch_decode(4'b0100, "load_rst");
        reset = 1'b0;
        #1;
        exp_push("midlda_reset_all", S_ALL, 64'd0);
        check();
        cyc();
        exp_push("midlda_reset_next", S_ALL, 64'd0);
        check();
        reset = 1'b1;
        cyc();
        exp_push("rel_fetch_state", S_STATE, 64'd1);
        exp_push("rel_fetch_mem_req", S_MREQ, 64'd1);
        check();

        // STOR with mem_ready on the limit cycle: transfer completes
        rsrc_in = 4'd4; rdst_in = 4'd11;
        fetch_decode(4'b0101, "stor_lim");
        for (int i = 1; i <= 15; i++) begin
            mem_ready = (i == 15);
            exp_push("stor_state", S_STATE, 64'd5);
            exp_push("stor_we", S_WE, 64'd1);
            exp_push("stor_pc_en", S_PCEN, 64'(i == 15));
            if (i == 1) begin
                exp_push("stor_ls", S_LS, 64'd1);
                exp_push("stor_rsrc", S_RSRC, 64'd4);
                exp_push("stor_rdst", S_RDST, 64'd11);
            end
            check();
            cyc();
        end
        mem_ready = 1'b0;
        exp_push("stor_lim_fetch", S_STATE, 64'd1);
        exp_push("stor_lim_no_bus_err", S_BUS, 64'd0);
        check();

        // STOR with mem_ready stuck low: timeout halt
        fetch_decode(4'b0101, "stor_to");
        for (int i = 1; i <= 15; i++) begin
            exp_push("stor_wait_state", S_STATE, 64'd5);
            check();
            cyc();
        end
        exp_push("timeout_halt", S_STATE, 64'd10);
        exp_push("timeout_bus_err", S_BUS, 64'd1);
        exp_push("timeout_mem_req", S_MREQ, 64'd0);
        exp_push("timeout_we", S_WE, 64'd0);
        check();
        cyc();
        exp_push("timeout_halt_stays", S_STATE, 64'd10);
        exp_push("timeout_bus_sticky", S_BUS, 64'd1);
        check();

        reset = 1'b0;
        cyc();
        exp_push("reset_clears_bus_err", S_BUS, 64'd0);
        check();
        reset = 1'b1;
        cyc();

        // Illegal class
        fetch_decode(4'b0111, "illegal");
        exp_push("ill_halt", S_STATE, 64'd10);
        exp_push("ill_flag", S_ILL, 64'd1);
        exp_push("ill_no_bus_err", S_BUS, 64'd0);
        exp_push("ill_pc_en", S_PCEN, 64'd0);
        check();
        cyc();
        exp_push("ill_halt_stays", S_STATE, 64'd10);
        exp_push("ill_sticky", S_ILL, 64'd1);
        check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
